wb_mem_responder: RTL
=====================

Name: wb_mem_responder

Overview:
- Wishbone classic-cycle responder that serves the cpu's `wb_*` master port; it is the slave end of the same bus.
- Backs a line-wide synchronous RAM with programmable wait states.
- Supports per-lane write select and raises `err` for out-of-range addresses.
- Serves as the simulation/FPGA main memory behind `memcontrol` cache refills and write-backs.

Parameters:
- DATA_WIDTH, 128, bus/line width in bits; equals the cpu's CACHE_WIDTH.
- GRANULARITY, 32, lane width in bits; address unit and sel granularity.
- ADDR_WIDTH, 32, width of `wb_adr_i`.
- DEPTH_LOG2, 10, log2 of number of DATA_WIDTH-bit lines stored.
- BASE_ADDR, 0, first lane address decoded (lane units).
- WAIT_STATES, 1, extra cycles inserted before the response (0..255).
- RETRY_PERIOD, 4, retry spacing; used only with the optional feature.
- Derived: SEL_WIDTH = DATA_WIDTH/GRANULARITY; LANE_BITS = log2(SEL_WIDTH).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low: 0 = reset.
- wb_adr_i  in  ADDR_WIDTH  lane address.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_dat_o  out  DATA_WIDTH  read data; valid only with ack.
- wb_we_i  in  1  1 = write.
- wb_sel_i  in  SEL_WIDTH  lane enables; bit k covers bits [k*GRANULARITY +: GRANULARITY].
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  bus cycle.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  retry termination (optional feature only; otherwise tied 0).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0, retry counter=0.
  - wb_ack_o=0, wb_err_o=0, wb_rty_o=0, wb_dat_o=0.
  - RAM contents are undefined and not cleared.
- Request: `wb_cyc_i & wb_stb_i` sampled in IDLE.
  - Latches adr, we, sel and dat_i into the request registers.
- Decode:
  - off = adr - BASE_ADDR, computed at ADDR_WIDTH bits unsigned.
  - In range iff adr >= BASE_ADDR and off < 2^(DEPTH_LOG2+LANE_BITS).
  - line = off[LANE_BITS +: DEPTH_LOG2]; off[LANE_BITS-1:0] is ignored.
- States:
  - IDLE: on request, go to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0; otherwise go directly to RESP.
  - WAIT: decrement each cycle; go to RESP when counter==0 on a clock edge.
  - RESP: exactly one of ack/err/rty is high for one cycle; next state is always IDLE.
    - Write commits on the RESP edge, only when the response is ack.
    - Read data is registered into wb_dat_o for the RESP cycle.
- Latency: the termination signal is high in cycle WAIT_STATES+1 counting the request-sampling edge as 0. WAIT_STATES=0 gives ack the cycle after stb is first seen.
- Handshake:
  - Terminations are single-cycle pulses.
  - IDLE after RESP forces one dead cycle, so a held stb is not double-served. Back-to-back requests are served every WAIT_STATES+2 cycles.
- Abort: if `wb_cyc_i` drops in WAIT or RESP, return to IDLE next cycle.
  - No write is performed, no termination is asserted; any pending ack is suppressed combinationally via `& wb_cyc_i`.
  - A `wb_stb_i` drop with cyc held does not abort.
- Out of range:
  - wb_err_o replaces ack; no write; wb_dat_o=0.
  - err takes priority over rty.
- Write with wb_sel_i=0: ack, RAM unchanged.
- Reads: wb_dat_o holds its last value after RESP until the next read response or reset. Masters must sample it only with ack.
- Simultaneous cases:
  - A new stb in the RESP cycle is ignored; it is sampled in the following IDLE.
  - Reset mid-WAIT discards the request without a write.

Optional Feature:
- Macro: WB_MEM_RETRY_EN.
- Defined:
  - Retry counter increments on each in-range request reaching RESP.
  - When the counter equals RETRY_PERIOD-1, the response is wb_rty_o instead of ack; no write, wb_dat_o=0, and the counter wraps to 0.
  - Exercises master retry paths.
- Undefined: retry counter removed; wb_rty_o is constant 0.

Test Plan:
- Reset: rst=0 asynchronously mid-cycle -> ack/err/rty=0 and wb_dat_o=0 immediately. Release -> IDLE, no spurious ack.
- Write/read round trip (WAIT_STATES=1, BASE_ADDR=0):
  - Write adr=0x10, sel=4'hF, dat=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> ack high exactly 2 cycles after stb sampled.
  - Read adr=0x13 -> same line returned; low lane bits are ignored.
- Partial write: write sel=4'b0010, dat lane1=32'hDEADBEEF to line 4 -> readback shows only bits [63:32] changed.
- Out of range: DEPTH_LOG2=10, read adr=0x1000 -> err pulse, dat_o=0, ack=0. Write to 0x1000 -> err, no RAM change at line 0.
- Abort: deassert cyc during WAIT of a write to 0x20 -> no ack. A subsequent read of 0x20 returns the old data.
- Retry (WB_MEM_RETRY_EN, RETRY_PERIOD=4): 8 consecutive reads -> requests 4 and 8 get rty with ack=0; others get ack. A repeated request after rty gets ack.

Source files
------------

// File: rtl/wb_mem_responder.sv
// -----------------------------------------------------------------------------
// wb_mem_responder
//
// Wishbone classic-cycle slave backed by a line-wide synchronous RAM. It
// terminates each cycle after a programmable number of wait states with ack,
// or with err for addresses outside the decoded window. It acts as the main
// memory behind cache refills and write-backs.
//
// Optional feature (compile-time macro WB_MEM_RETRY_EN):
//   every RETRY_PERIOD-th in-range request is answered with rty instead of
//   ack, without touching memory. Without the macro the retry counter does
//   not exist and wb_rty_o is tied low.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset (0 = reset)
//   wb_adr_i   in   lane address (GRANULARITY-bit units)
//   wb_dat_i   in   write data, one full line
//   wb_dat_o   out  read data, valid only together with ack
//   wb_we_i    in   1 = write
//   wb_sel_i   in   lane enables, bit k covers [k*GRANULARITY +: GRANULARITY]
//   wb_stb_i   in   strobe
//   wb_cyc_i   in   bus cycle
//   wb_ack_o   out  normal termination (single-cycle pulse)
//   wb_err_o   out  error termination (single-cycle pulse)
//   wb_rty_o   out  retry termination (optional feature only)
// -----------------------------------------------------------------------------
module wb_mem_responder #(
    parameter int                    DATA_WIDTH   = 128,
    parameter int                    GRANULARITY  = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DEPTH_LOG2   = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    WAIT_STATES  = 1,
    parameter int                    RETRY_PERIOD = 4,
    localparam int                   SEL_WIDTH    = DATA_WIDTH / GRANULARITY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic                  wb_we_i,
    input  logic [SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o
);

    localparam int LANE_BITS = $clog2(SEL_WIDTH);
    localparam int SPAN_BITS = DEPTH_LOG2 + LANE_BITS;
    localparam int DEPTH     = 1 << DEPTH_LOG2;

    if (WAIT_STATES < 0 || WAIT_STATES > 255 || RETRY_PERIOD < 1 ||
        (DATA_WIDTH % GRANULARITY) != 0) begin : g_param_check
        $error("wb_mem_responder: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  state_q,    state_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q,      adr_d;
    logic                    we_q,       we_d;
    logic [SEL_WIDTH-1:0]    sel_q,      sel_d;
    logic [DATA_WIDTH-1:0]   wdat_q,     wdat_d;
    logic                    ack_q,      ack_d;
    logic                    err_q,      err_d;
    logic [DATA_WIDTH-1:0]   rdata_q,    rdata_d;

    logic [SEL_WIDTH-1:0][GRANULARITY-1:0] mem [DEPTH];

    // In IDLE the request has not been latched yet, so decode straight from
    // the bus; this is what lets WAIT_STATES=0 answer on the very next cycle.
    logic [ADDR_WIDTH-1:0]   cur_adr;
    logic                    cur_we;
    logic [ADDR_WIDTH-1:0]   cur_off;
    logic                    cur_in_range;
    logic [DEPTH_LOG2-1:0]   cur_line;
    logic                    enter_resp;
    logic                    do_write;

    assign cur_adr      = (state_q == ST_IDLE) ? wb_adr_i : adr_q;
    assign cur_we       = (state_q == ST_IDLE) ? wb_we_i  : we_q;
    assign cur_off      = cur_adr - BASE_ADDR;
    // The shift test avoids building 2^SPAN_BITS as a constant that might not
    // fit in ADDR_WIDTH bits.
    assign cur_in_range = (cur_adr >= BASE_ADDR) && ((cur_off >> SPAN_BITS) == '0);
    assign cur_line     = cur_off[LANE_BITS +: DEPTH_LOG2];

`ifdef WB_MEM_RETRY_EN
    localparam int RETRY_W = (RETRY_PERIOD > 1) ? $clog2(RETRY_PERIOD) : 1;

    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic               rty_q,       rty_d;
    logic               retry_hit;

    assign retry_hit = (retry_cnt_q == RETRY_W'(RETRY_PERIOD - 1));
`endif

    // Next-state and response decision. The response type and read data are
    // chosen on the edge that enters RESP so all terminations come from flops.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        adr_d      = adr_q;
        we_d       = we_q;
        sel_d      = sel_q;
        wdat_d     = wdat_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        enter_resp = 1'b0;
`ifdef WB_MEM_RETRY_EN
        retry_cnt_d = retry_cnt_q;
        rty_d       = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d  = wb_adr_i;
                    we_d   = wb_we_i;
                    sel_d  = wb_sel_i;
                    wdat_d = wb_dat_i;
                    if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = 8'(WAIT_STATES - 1);
                    end else begin
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Only cyc aborts; a dropped stb with cyc held keeps waiting.
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == 8'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                // Unconditional return to IDLE gives the dead cycle that keeps
                // a held strobe from being served twice.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            state_d = ST_RESP;
            if (!cur_in_range) begin
                err_d   = 1'b1;
                rdata_d = '0;
            end
`ifdef WB_MEM_RETRY_EN
            else if (retry_hit) begin
                rty_d       = 1'b1;
                rdata_d     = '0;
                retry_cnt_d = '0;
            end
`endif
            else begin
                ack_d = 1'b1;
`ifdef WB_MEM_RETRY_EN
                retry_cnt_d = retry_cnt_q + RETRY_W'(1);
`endif
                if (!cur_we) begin
                    rdata_d = mem[cur_line];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 8'd0;
            adr_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            wdat_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
`ifdef WB_MEM_RETRY_EN
            retry_cnt_q <= '0;
            rty_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            adr_q      <= adr_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            wdat_q     <= wdat_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
`ifdef WB_MEM_RETRY_EN
            retry_cnt_q <= retry_cnt_d;
            rty_q       <= rty_d;
`endif
        end
    end

    // The write lands on the edge that leaves RESP, and only if the master is
    // still in the cycle; ack_q is low for err/rty so those never write.
    assign do_write = (state_q == ST_RESP) && ack_q && we_q && wb_cyc_i;

    // Memory array has no reset so it maps onto block RAM lane write enables.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < SEL_WIDTH; k++) begin
                if (sel_q[k]) begin
                    mem[cur_line][k] <= wdat_q[k*GRANULARITY +: GRANULARITY];
                end
            end
        end
    end

    // Gating with cyc suppresses a termination whose cycle was abandoned.
    assign wb_dat_o = rdata_q;
    assign wb_ack_o = ack_q & wb_cyc_i;
    assign wb_err_o = err_q & wb_cyc_i;
`ifdef WB_MEM_RETRY_EN
    assign wb_rty_o = rty_q & wb_cyc_i;
`else
    assign wb_rty_o = 1'b0;
`endif

endmodule
